// File: rtl/spike_encoder.sv
// rtl/spike_encoder.sv - pixel stream to temporal spike-time encoder with double-buffered volleys
// Brighter pixels spike earlier; one volley plays out while the next image loads.
module spike_encoder #(
    parameter int NUM_SPIKES      = 16,
    parameter int LOG_TIME_PERIOD = 3,
    parameter int TIME_PERIOD     = 8,
    parameter int PIX_BITS        = 8,
    parameter int THRESH          = 64
) (
    input  logic                                         clk,
    input  logic                                         rst_l,
    input  logic                                         pix_valid,
    output logic                                         pix_ready,
    input  logic [PIX_BITS-1:0]                          pix_data,
    input  logic                                         pix_last,
    input  logic                                         train_in,
    output logic [LOG_TIME_PERIOD:0]                     time_val,
    output logic [NUM_SPIKES*(LOG_TIME_PERIOD+1)-1:0]    spike_times,
    output logic                                         training,
    output logic                                         volley_start,
    output logic                                         busy,
    output logic                                         err
);

    localparam int TW = LOG_TIME_PERIOD + 1;
    localparam int IW = (NUM_SPIKES > 1) ? $clog2(NUM_SPIKES) : 1;
    localparam logic [TW-1:0]       NO_SPIKE = {1'b1, {LOG_TIME_PERIOD{1'b0}}};
    localparam logic [TW-1:0]       T_LAST   = TW'(TIME_PERIOD - 1);
    localparam logic [IW-1:0]       IDX_LAST = IW'(NUM_SPIKES - 1);
    localparam logic [PIX_BITS-1:0] PIX_MAX  = {PIX_BITS{1'b1}};
    localparam logic [PIX_BITS-1:0] PIX_TH   = PIX_BITS'(THRESH);
    localparam logic [PIX_BITS-1:0] PIX_TCAP = PIX_BITS'(TIME_PERIOD - 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic                           w_swap;

    logic [NUM_SPIKES-1:0][TW-1:0]  r_load;
    logic [NUM_SPIKES-1:0][TW-1:0]  r_active;
    logic                           r_load_train;
    logic                           r_active_train;
    logic [IW-1:0]                  r_idx;
    logic                           r_pending;
    logic                           r_err;
    logic [TW-1:0]                  r_time;
    logic                           r_volley_start;

    logic [PIX_BITS-1:0]            w_inv;
    logic [PIX_BITS-1:0]            w_coarse;
    logic [TW-1:0]                  w_code;
    logic                           w_hs;
    logic                           w_at_last;
    logic                           w_img_done;
    logic                           w_frame_err;

    // Darkness scaled down to the time field, saturating at the final slot
    always_comb begin
        w_inv    = PIX_MAX - pix_data;
        w_coarse = w_inv >> (PIX_BITS - LOG_TIME_PERIOD);
        w_code   = NO_SPIKE;
        if (pix_data >= PIX_TH) begin
            if (w_coarse > PIX_TCAP) begin
                w_code = {1'b0, T_LAST[LOG_TIME_PERIOD-1:0]};
            end else begin
                w_code = {1'b0, w_coarse[LOG_TIME_PERIOD-1:0]};
            end
        end
    end

    assign w_hs        = pix_valid & ~r_pending;
    assign w_at_last   = (r_idx == IDX_LAST);
    assign w_img_done  = w_hs & pix_last & w_at_last;
    assign w_frame_err = w_hs & (pix_last ^ w_at_last);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_swap       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_swap       = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_time == T_LAST) begin
                    if (r_pending) begin
                        w_swap = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Handshake and swap never coincide: one needs pending low, the other high
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_load       <= {NUM_SPIKES{NO_SPIKE}};
            r_load_train <= 1'b0;
            r_idx        <= '0;
            r_pending    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (w_hs) begin
                r_load[r_idx] <= w_code;
                if (r_idx == '0) begin
                    r_load_train <= train_in;
                end
                if (w_img_done) begin
                    r_pending <= 1'b1;
                    r_idx     <= '0;
                end else if (w_frame_err) begin
                    r_err <= 1'b1;
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + IW'(1);
                end
            end else if (w_swap) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_active       <= {NUM_SPIKES{NO_SPIKE}};
            r_active_train <= 1'b0;
            r_time         <= T_LAST;
            r_volley_start <= 1'b0;
        end else begin
            r_volley_start <= w_swap;
            if (w_swap) begin
                r_active       <= r_load;
                r_active_train <= r_load_train;
                r_time         <= '0;
            end else if (r_state == S_RUN && r_time != T_LAST) begin
                r_time <= r_time + TW'(1);
            end
        end
    end

    assign pix_ready    = ~r_pending;
    assign time_val     = r_time;
    assign busy         = (r_state == S_RUN);
    assign spike_times  = busy ? r_active : {NUM_SPIKES{NO_SPIKE}};
    assign training     = busy & r_active_train;
    assign volley_start = r_volley_start;
    assign err          = r_err;

endmodule

// File: tb/tb_spike_encoder.sv
// tb/tb_spike_encoder.sv - scoreboard bench for spike_encoder (16-input and 4-input instances)
module tb_spike_encoder;

    logic        clk;
    logic        rst_l;

    logic        pv_a, pr_a, pl_a, tr_a, trn_a, vs_a, busy_a, err_a;
    logic [7:0]  pd_a;
    logic [3:0]  tv_a;
    logic [63:0] st_a;

    logic        pv_b, pr_b, pl_b, tr_b, trn_b, vs_b, busy_b, err_b;
    logic [7:0]  pd_b;
    logic [3:0]  tv_b;
    logic [15:0] st_b;

    typedef struct {
        logic [3:0]  tv;
        logic [63:0] st;
        logic        tr;
        logic        vs;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [7:0]  pix_tab[16];
    int          checks = 0;
    int          errors = 0;

    localparam logic [63:0] EXP_A1   = 64'h33333333_33388450;
    localparam logic [63:0] EXP_C    = 64'h00112233_44558888;
    localparam logic [63:0] NOSP_A   = 64'h88888888_88888888;
    localparam logic [15:0] EXP_B1   = 16'h3810;
    localparam logic [15:0] EXP_B2   = 16'h8045;
    localparam logic [15:0] EXP_B3   = 16'h1533;
    localparam logic [15:0] NOSP_B   = 16'h8888;

    spike_encoder u_dut_a (
        .clk(clk), .rst_l(rst_l), .pix_valid(pv_a), .pix_ready(pr_a), .pix_data(pd_a),
        .pix_last(pl_a), .train_in(tr_a), .time_val(tv_a), .spike_times(st_a),
        .training(trn_a), .volley_start(vs_a), .busy(busy_a), .err(err_a)
    );

    spike_encoder #(.NUM_SPIKES(4)) u_dut_b (
        .clk(clk), .rst_l(rst_l), .pix_valid(pv_b), .pix_ready(pr_b), .pix_data(pd_b),
        .pix_last(pl_b), .train_in(tr_b), .time_val(tv_b), .spike_times(st_b),
        .training(trn_b), .volley_start(vs_b), .busy(busy_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic push_volley(input int sel, input logic [63:0] st, input logic tr);
        exp_t e;
        for (int t = 0; t < 8; t++) begin
            e.tv = 4'(t);
            e.st = st;
            e.tr = tr;
            e.vs = (t == 0);
            if (sel == 0) q_a.push_back(e);
            else          q_b.push_back(e);
        end
    endtask

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst_l && busy_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL volley_a: unexpected output tv=%h st=%h, none expected", tv_a, st_a);
            end else begin
                e = q_a.pop_front();
                chk("volley_a", 70'({tv_a, st_a, trn_a, vs_a}), 70'({e.tv, e.st, e.tr, e.vs}));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst_l && busy_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL volley_b: unexpected output tv=%h st=%h, none expected", tv_b, st_b);
            end else begin
                e = q_b.pop_front();
                chk("volley_b", 70'({tv_b, st_b, trn_b, vs_b}), 70'({e.tv, e.st[15:0], e.tr, e.vs}));
            end
        end
    end

    task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic l, input logic t);
        if (sel == 0) begin
            pv_a = v; pd_a = d; pl_a = l; tr_a = t;
        end else begin
            pv_b = v; pd_b = d; pl_b = l; tr_b = t;
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? pr_a : pr_b;
    endfunction

    task automatic send_pix(input int sel, input logic [7:0] d, input logic l, input logic t);
        int n;
        n = 0;
        drive(sel, 1'b1, d, l, t);
        while (!rdy(sel) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: pix_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(negedge clk);
        drive(sel, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_img(input int sel, input int cnt, input logic last_fin, input logic t);
        for (int i = 0; i < cnt; i++) begin
            send_pix(sel, pix_tab[i], (i == cnt - 1) ? last_fin : 1'b0, t);
        end
    endtask

    task automatic wait_busy(input int sel, input logic level);
        int n;
        n = 0;
        while (((sel == 0) ? busy_a : busy_b) !== level && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_busy: busy never reached %0b", level);
        end
    endtask

    task automatic wait_time(input int sel, input logic [3:0] tv);
        int n;
        n = 0;
        while (!(((sel == 0) ? busy_a : busy_b) && (((sel == 0) ? tv_a : tv_b) == tv)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_time: time_val never reached %0d while busy", tv);
        end
    endtask

    task automatic run_volley(input int sel);
        wait_busy(sel, 1'b1);
        wait_busy(sel, 1'b0);
    endtask

    initial begin
        int seen;
        rst_l = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);

        chk("reset_a", 70'({tv_a, st_a, pr_a, busy_a, err_a, trn_a, vs_a}),
            70'({4'd7, NOSP_A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        chk("reset_b", 70'({tv_b, st_b, pr_b, busy_b, err_b, trn_b, vs_b}),
            70'({4'd7, NOSP_B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        rst_l = 1'b1;
        @(negedge clk);

        // Encoding volley on the 16-input instance
        pix_tab[0] = 8'd255; pix_tab[1] = 8'd64; pix_tab[2] = 8'd100;
        pix_tab[3] = 8'd63;  pix_tab[4] = 8'd0;
        for (int i = 5; i < 16; i++) pix_tab[i] = 8'd128;
        push_volley(0, EXP_A1, 1'b1);
        send_img(0, 16, 1'b1, 1'b1);
        chk("a_after_last", 70'({pr_a, busy_a}), 70'({1'b0, 1'b0}));
        run_volley(0);
        chk("a_idle_after", 70'({tv_a, st_a, trn_a, err_a, pr_a}),
            70'({4'd7, NOSP_A, 1'b0, 1'b0, 1'b1}));

        // Back-to-back volleys on the 4-input instance
        pix_tab[0] = 8'd255; pix_tab[1] = 8'd200; pix_tab[2] = 8'd63; pix_tab[3] = 8'd128;
        push_volley(1, 64'(EXP_B1), 1'b1);
        send_img(1, 4, 1'b1, 1'b1);
        pix_tab[0] = 8'd64; pix_tab[1] = 8'd100; pix_tab[2] = 8'd255; pix_tab[3] = 8'd0;
        push_volley(1, 64'(EXP_B2), 1'b0);
        send_img(1, 4, 1'b1, 1'b0);
        chk("b2_ready_low", 70'(pr_b), 70'(1'b0));
        wait_time(1, 4'd7);
        chk("b1_end_pending", 70'({busy_b, pr_b}), 70'({1'b1, 1'b0}));
        @(negedge clk);
        chk("b2b_start", 70'({busy_b, tv_b, vs_b, pr_b}), 70'({1'b1, 4'd0, 1'b1, 1'b1}));

        // Last pixel lands on the time_val=7 edge
        send_pix(1, 8'd128, 1'b0, 1'b1);
        send_pix(1, 8'd128, 1'b0, 1'b0);
        send_pix(1, 8'd64, 1'b0, 1'b0);
        wait_time(1, 4'd7);
        push_volley(1, 64'(EXP_B3), 1'b1);
        send_pix(1, 8'd200, 1'b1, 1'b0);
        chk("collide_idle", 70'({busy_b, tv_b, vs_b, pr_b, st_b}),
            70'({1'b0, 4'd7, 1'b0, 1'b0, NOSP_B}));
        @(negedge clk);
        chk("collide_start", 70'({busy_b, tv_b, vs_b, pr_b}), 70'({1'b1, 4'd0, 1'b1, 1'b1}));
        wait_busy(1, 1'b0);

        // Missing pix_last on the final pixel
        pix_tab[0] = 8'd255; pix_tab[1] = 8'd255; pix_tab[2] = 8'd255; pix_tab[3] = 8'd255;
        send_img(1, 4, 1'b0, 1'b0);
        chk("b_err_nolast", 70'({err_b, pr_b}), 70'({1'b1, 1'b1}));
        repeat (3) @(negedge clk);
        chk("b_no_volley", 70'(busy_b), 70'(1'b0));

        // Early pix_last on the 10th pixel
        for (int i = 0; i < 16; i++) pix_tab[i] = 8'd128;
        send_img(0, 10, 1'b1, 1'b0);
        chk("a_err_early", 70'({err_a, pr_a}), 70'({1'b1, 1'b1}));
        repeat (3) @(negedge clk);
        chk("a_no_volley", 70'(busy_a), 70'(1'b0));
        for (int i = 0; i < 16; i++) pix_tab[i] = 8'(i * 16);
        push_volley(0, EXP_C, 1'b0);
        send_img(0, 16, 1'b1, 1'b0);
        run_volley(0);
        chk("a_err_sticky", 70'({err_a, tv_a}), 70'({1'b1, 4'd7}));

        // Reset in the middle of a volley
        pix_tab[0] = 8'd255; pix_tab[1] = 8'd64; pix_tab[2] = 8'd100;
        pix_tab[3] = 8'd63;  pix_tab[4] = 8'd0;
        for (int i = 5; i < 16; i++) pix_tab[i] = 8'd128;
        push_volley(0, EXP_A1, 1'b0);
        send_img(0, 16, 1'b1, 1'b0);
        wait_time(0, 4'd3);
        #2 rst_l = 1'b0;
        #1;
        chk("async_reset_a", 70'({tv_a, st_a, pr_a, busy_a, err_a, trn_a, vs_a}),
            70'({4'd7, NOSP_A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
        chk("async_reset_b", 70'({err_b, pr_b, busy_b}), 70'({1'b0, 1'b1, 1'b0}));
        q_a.delete();
        @(negedge clk);
        rst_l = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy_a || busy_b) seen = 1;
        end
        chk("no_volley_after_reset", 70'(seen), 70'(0));
        for (int i = 0; i < 16; i++) pix_tab[i] = 8'(i * 16);
        push_volley(0, EXP_C, 1'b1);
        send_img(0, 16, 1'b1, 1'b1);
        run_volley(0);
        chk("post_reset_idle", 70'({err_a, tv_a, pr_a}), 70'({1'b0, 4'd7, 1'b1}));

        chk("queues_drained", 70'({q_a.size(), q_b.size()}), 70'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_encoder.md
# spike_encoder

Front end of the column datapath, directly upstream of the spiking layer. It accepts one image as a stream of pixel intensities and converts each pixel to a temporally coded spike time, using an earlier spike for a brighter pixel. It double-buffers the resulting volley and sequences gamma cycles, driving `time_val`, `spike_times` and `training` into the layer. One volley runs for TIME_PERIOD cycles while the next image loads.

## Interface
Parameters:
- NUM_SPIKES, 16: pixels per image; equals layer input count.
- LOG_TIME_PERIOD, 3: spike-time field width.
- TIME_PERIOD, 8: cycles per gamma cycle; TIME_PERIOD ≤ 2^LOG_TIME_PERIOD.
- PIX_BITS, 8: pixel width; PIX_BITS ≥ LOG_TIME_PERIOD.
- THRESH, 64: pixels below this produce no spike.

Ports:
- clk  in  1  clock.
- rst_l  in  1  reset, asynchronous, active-low.
- pix_valid  in  1  pixel present.
- pix_ready  out  1  encoder can accept a pixel.
- pix_data  in  PIX_BITS  pixel intensity.
- pix_last  in  1  final pixel of image.
- train_in  in  1  training flag; sampled with the first pixel of an image.
- time_val  out  LOG_TIME_PERIOD+1  gamma-cycle time.
- spike_times  out  NUM_SPIKES×(LOG_TIME_PERIOD+1)  per-input `{no_spike_l, time}`; MSB=1 means no spike.
- training  out  1  STDP enable for the current volley.
- volley_start  out  1  one-cycle pulse; time_val=0 of a new volley.
- busy  out  1  a volley is running.
- err  out  1  sticky framing error.

## Operation
- **Encoding (at write):**
  - If pix < THRESH, store `{1, 0}`.
  - Otherwise t = ((2^PIX_BITS−1) − pix) >> (PIX_BITS−LOG_TIME_PERIOD), clamped to TIME_PERIOD−1; store `{0, t}`.
  - Arithmetic is unsigned, PIX_BITS wide, with no overflow.
- **Load buffer:**
  - A write index 0..NUM_SPIKES−1 advances on each handshake (pix_valid & pix_ready).
  - train_in is captured when index=0.
  - When index=NUM_SPIKES−1 and pix_last=1: set `pending`, reset index to 0.
- **Framing errors:**
  - pix_last=1 at index≠NUM_SPIKES−1: set err, discard the partial image (index→0), do not set pending.
  - pix_last=0 at index=NUM_SPIKES−1: same handling.
- **pix_ready** = !pending.
- **Active buffer** drives spike_times; `training` comes from the train flag stored with it.
- **FSM IDLE:**
  - time_val = TIME_PERIOD−1, all spike_times = `{1,0}`, training=0, busy=0.
  - If pending: swap load→active, clear pending, time_val←0, volley_start=1, go RUN.
- **FSM RUN:**
  - time_val increments each cycle and busy=1.
  - At time_val=TIME_PERIOD−1:
    - if pending, swap as above (back-to-back volleys, no gap);
    - else go IDLE, keeping time_val at TIME_PERIOD−1 and setting spike_times to all no-spike.
- spike_times and training are stable for the entire volley, including the TIME_PERIOD−1 cycle that the layer uses for STDP.
- err clears only on reset.

## Timing
- **Reset values:**
  - time_val = TIME_PERIOD−1, spike_times all `{1,0}`;
  - training=0, volley_start=0, busy=0, err=0;
  - pix_ready=1, index=0, pending=0, FSM=IDLE.
- **Latency:**
  - Last pixel accepted at edge e → pending=1 after e.
  - From IDLE, time_val=0 and volley_start=1 after edge e+1.
- **Throughput:** a full image may load during a volley. With back-to-back images, volleys are contiguous (time_val …,TIME_PERIOD−1,0,…).
- **pix_ready:**
  - falls the cycle after the last pixel is accepted;
  - rises the cycle after the swap edge.
  - Data is held by the sender while ready=0.
- **Simultaneous events:** if the last pixel is accepted on the same edge as time_val=TIME_PERIOD−1 in RUN, pending is not yet visible. The FSM enters IDLE for exactly one cycle, then starts the new volley.
- **Reset mid-volley or mid-load:** all state returns to reset values immediately, and the partial image is lost.

## Test plan
1. **Reset values:** reset → time_val=7, every spike_times entry=4'b1000, pix_ready=1, busy=0, err=0.
2. **Encoding:**
   - Load 16 pixels with pix_data = 255, 64, 100, 63, 0, then 128 for the rest, train_in=1.
   - Expected entries: 0→4'b0000, 1→4'b0101, 2→4'b0100, 3 and 4→4'b1000, remaining→4'b0011.
   - volley_start after the last pixel, time_val 0..7, training=1 throughout.
   - After the volley, IDLE with time_val=7.
3. **Back-to-back:**
   - Stream a second image during volley 1.
   - pix_ready=0 after the 16th pixel.
   - time_val goes 7→0 with volley_start=1 and no IDLE cycle.
   - pix_ready=1 the next cycle.
4. **Boundary collision:** second image's last pixel accepted on the time_val=7 edge → one IDLE cycle (time_val=7, busy=0), then volley_start.
5. **Framing errors:**
   - pix_last on the 10th pixel → err=1, no volley.
   - A following correct image then runs normally, with err still 1.
6. **Reset mid-volley:** rst_l low at time_val=3 → outputs at reset values asynchronously; no volley after release until a new image loads.
